matriz_varredura: RTL
=====================

# matriz_varredura

Row-scan controller for the 7×5 LED matrix. It time-multiplexes the seven matrix rows by driving the 3-bit row code (A, B, C) into the row decoder, and presents the matching 5-bit column pattern for each row. It inserts a blanking interval before each row. New frames are accepted through a ready/load handshake and swapped in only at frame boundaries, so the display never shows a half-updated frame.

## Interface
- DIV, 8, clock cycles per row period (BLANK + show); must satisfy DIV > BLANK
- BLANK, 2, blanking cycles at the start of each row; must be ≥ 1
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  reset, synchronous, active-high
- en  input  1  scan enable; when low, the display is blanked
- load  input  1  one-cycle frame-load strobe; sampled only when ready=1
- frame_in  input  35  frame pattern; bits [5(k-1)+4 : 5(k-1)] hold row k (k = 1..7); bit 4 of each slice is column 1
- ready  output  1  shadow register empty; a load is accepted in this cycle
- A, B, C  output  1 each  row code to the decoder (A is the MSB)
- col  output  5  column drive for the current row
- frame_done  output  1  one-cycle pulse at the end of row 7

## Operation
- Row code mapping: row k is selected by ABC = 7−k. Row 1 = 110, row 7 = 000.
- Code 111 selects no row. It is used for blanking and idle.
- Storage:
  - active[34:0] holds the frame being displayed.
  - shadow[34:0] holds a frame waiting to be shown.
  - pending flag marks that shadow is full; ready = ~pending.
- FSM states:
  - IDLE: ABC=111, col=0, cnt=0, row=1. Moves to BLANK when en=1.
  - BLANK: ABC=111, col=0. After BLANK cycles, moves to SHOW.
  - SHOW: ABC = code(row), col = active slice for row. At cnt=DIV−1:
    - If row<7: row+1, cnt=0, move to BLANK.
    - If row=7: row=1, pulse frame_done, swap if pending, move to BLANK.
- cnt counts 0..DIV−1 across BLANK+SHOW within one row and wraps at DIV−1.
- Load handshake: when load=1 and ready=1, capture frame_in into shadow and set pending. When ready=0, load is ignored (no capture, no error).
- Swap: active ← shadow and pending cleared at the last SHOW cycle of row 7. In IDLE, the swap happens on the cycle after pending is set.
- Simultaneous swap and load in the same cycle: the swap takes priority. ready is 0 that cycle, so the load is ignored. ready becomes 1 the next cycle.
- en deasserted mid-row: next cycle goes to IDLE. The current row is abandoned, row and cnt reset, and no frame_done pulse is given. A pending frame swaps while in IDLE.
- rst during any state forces reset values on the next edge and discards any pending frame.
- Reset values: state=IDLE, ABC=111, col=00000, frame_done=0, ready=1, active=0, shadow=0, row=1, cnt=0.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- en rise at edge t: ABC=111 from t+1. First SHOW cycle of row 1 is at t+1+BLANK.
- Row period is exactly DIV cycles; frame period is 7·DIV cycles.
- col changes only on BLANK↔SHOW transitions, and is 0 whenever ABC=111.
- frame_done is high during the last SHOW cycle of row 7, the same cycle the swap occurs. The new frame appears at the first SHOW cycle of row 1.
- Load-to-ready latency: ready falls one cycle after an accepted load. It rises one cycle after the swap.

## Test plan
- Reset and idle: assert rst with en=1 → next cycle ABC=111, col=0, ready=1, frame_done=0; hold en=0 for 20 cycles → outputs unchanged.
- Full scan (DIV=8, BLANK=2): load rows = 10000, 01000, 00100, 00010, 00001, 11111, 10101 with en=0, then raise en:
  - Each row shows 2 cycles of ABC=111/col=0, then 6 cycles of ABC = 110, 101, 100, 011, 010, 001, 000 with the matching col.
  - frame_done pulses once every 56 cycles.
- Tear-free swap: load frame B during row 3 of frame A → ready=0 next cycle; rows 4–7 still show A; frame B appears at row 1 SHOW; ready=1 one cycle after frame_done.
- Rejected load: issue a second load while ready=0 → shadow unchanged; the first queued frame is displayed.
- Swap/load collision: assert load in the frame_done cycle → load ignored; ready=1 the following cycle.
- Mid-operation disruption:
  - Drop en during row 4 SHOW → next cycle ABC=111, col=0, no frame_done; re-raise en → scan restarts at row 1 after BLANK cycles.
  - Assert rst mid-row with pending=1 → reset values; the pending frame is never displayed.

Source files
------------

// File: rtl/matriz_varredura_if.sv
// Frame-load handshake and row/column drive bundle for the 7x5 LED matrix scanner.
interface matriz_varredura_if;
    logic        en;
    logic        load;
    logic [34:0] frame_in;
    logic        ready;
    logic        A;
    logic        B;
    logic        C;
    logic [4:0]  col;
    logic        frame_done;

    modport master (
        output en, load, frame_in,
        input  ready, A, B, C, col, frame_done
    );

    modport slave (
        input  en, load, frame_in,
        output ready, A, B, C, col, frame_done
    );
endinterface

// File: rtl/matriz_varredura.sv
// Row-scan controller for a 7x5 LED matrix: blanking before every row, double-buffered
// frames swapped only at frame boundaries (or immediately while idle).
module matriz_varredura #(
    parameter int DIV   = 8,
    parameter int BLANK = 2
) (
    input  logic             clk,
    input  logic             rst,
    matriz_varredura_if.slave bus
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t        state_r, state_nx_s;
    logic [CW-1:0] cnt_r, cnt_nx_s;
    logic [2:0]    row_r, row_nx_s;
    logic [34:0]   active_r, shadow_r, active_nx_s;
    logic          pending_r;
    logic          frame_end_s, swap_s, accept_s;
    logic [2:0]    abc_r, abc_nx_s;
    logic [4:0]    col_r, col_nx_s;
    logic          done_r, done_nx_s;

    // Row k lives in bits [5(k-1)+4 : 5(k-1)]; bit 4 of the slice is column 1.
    function automatic logic [4:0] row_slice(input logic [34:0] f, input logic [2:0] r);
        logic [4:0] s;
        case (r)
            3'd1:    s = f[4:0];
            3'd2:    s = f[9:5];
            3'd3:    s = f[14:10];
            3'd4:    s = f[19:15];
            3'd5:    s = f[24:20];
            3'd6:    s = f[29:25];
            3'd7:    s = f[34:30];
            default: s = 5'd0;
        endcase
        return s;
    endfunction

    assign frame_end_s = (state_r == ST_SHOW) && (row_r == 3'd7) && (cnt_r == CNT_LAST);
    // Swap wins over a same-cycle load because the load needs pending clear.
    assign swap_s      = pending_r && (frame_end_s || (state_r == ST_IDLE));
    assign accept_s    = bus.load && !pending_r;
    assign active_nx_s = swap_s ? shadow_r : active_r;

    // State, counter and row register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            row_r   <= 3'd1;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            row_r   <= row_nx_s;
        end
    end

    // Next-state logic; losing en abandons the row and returns to idle.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        row_nx_s   = row_r;
        case (state_r)
            ST_IDLE: begin
                cnt_nx_s = '0;
                row_nx_s = 3'd1;
                if (bus.en) begin
                    state_nx_s = ST_BLANK;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_BLANK: begin
                if (!bus.en) begin
                    state_nx_s = ST_IDLE;
                    cnt_nx_s   = '0;
                    row_nx_s   = 3'd1;
                end else if (cnt_r == BLANK_LAST) begin
                    state_nx_s = ST_SHOW;
                    cnt_nx_s   = cnt_r + CNT_ONE;
                end else begin
                    state_nx_s = ST_BLANK;
                    cnt_nx_s   = cnt_r + CNT_ONE;
                end
            end
            ST_SHOW: begin
                if (!bus.en) begin
                    state_nx_s = ST_IDLE;
                    cnt_nx_s   = '0;
                    row_nx_s   = 3'd1;
                end else if (cnt_r == CNT_LAST) begin
                    state_nx_s = ST_BLANK;
                    cnt_nx_s   = '0;
                    if (row_r == 3'd7) begin
                        row_nx_s = 3'd1;
                    end else begin
                        row_nx_s = row_r + 3'd1;
                    end
                end else begin
                    state_nx_s = ST_SHOW;
                    cnt_nx_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = '0;
                row_nx_s   = 3'd1;
            end
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up with it.
    always_comb begin
        abc_nx_s  = 3'b111;
        col_nx_s  = 5'd0;
        done_nx_s = 1'b0;
        case (state_nx_s)
            ST_SHOW: begin
                abc_nx_s  = 3'd7 - row_nx_s;
                col_nx_s  = row_slice(active_nx_s, row_nx_s);
                done_nx_s = (row_nx_s == 3'd7) && (cnt_nx_s == CNT_LAST);
            end
            default: begin
                abc_nx_s  = 3'b111;
                col_nx_s  = 5'd0;
                done_nx_s = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            abc_r  <= 3'b111;
            col_r  <= 5'd0;
            done_r <= 1'b0;
        end else begin
            abc_r  <= abc_nx_s;
            col_r  <= col_nx_s;
            done_r <= done_nx_s;
        end
    end

    // Frame double buffer and pending flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_r  <= 35'd0;
            shadow_r  <= 35'd0;
            pending_r <= 1'b0;
        end else if (swap_s) begin
            active_r  <= shadow_r;
            pending_r <= 1'b0;
        end else if (accept_s) begin
            shadow_r  <= bus.frame_in;
            pending_r <= 1'b1;
        end
    end

    assign bus.ready      = ~pending_r;
    assign bus.A          = abc_r[2];
    assign bus.B          = abc_r[1];
    assign bus.C          = abc_r[0];
    assign bus.col        = col_r;
    assign bus.frame_done = done_r;

endmodule
